// File: rtl/sprite_blitter.sv
// Sprite-to-framebuffer writer: walks the sprite footprint in raster order, fetches texels
// from a synchronous ROM and issues clipped, colour-keyed pixel writes over valid/ready.
module sprite_blitter #(
  parameter int                HWIDTH   = 10,
  parameter int                VWIDTH   = 10,
  parameter int                AWIDTH   = 12,
  parameter int                IWIDTH   = 0,
  parameter int                DWIDTH   = 12,
  parameter int                HSIZE    = 64,
  parameter int                VSIZE    = 64,
  parameter int                SCREEN_H = 640,
  parameter int                SCREEN_V = 480,
  parameter logic [DWIDTH-1:0] TRANSP   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [HWIDTH-1:0] hoffset,
  input  logic [VWIDTH-1:0] voffset,
  input  logic              hflip,
  input  logic              vflip,
  output logic              busy,
  output logic              done,
  output logic [AWIDTH-1:0] rom_addr,
  input  logic [DWIDTH-1:0] rom_data,
  output logic [HWIDTH-1:0] fb_hdata,
  output logic [VWIDTH-1:0] fb_vdata,
  output logic [DWIDTH-1:0] fb_data,
  output logic              fb_valid,
  input  logic              fb_ready
);

  localparam int XW = (HSIZE > 1) ? $clog2(HSIZE) : 1;
  localparam int YW = (VSIZE > 1) ? $clog2(VSIZE) : 1;
  localparam logic [XW-1:0]     X_LAST  = XW'(HSIZE - 1);
  localparam logic [YW-1:0]     Y_LAST  = YW'(VSIZE - 1);
  localparam logic [AWIDTH-1:0] TEX_W   = AWIDTH'(HSIZE >> IWIDTH);
  localparam logic [HWIDTH-1:0] HSIZE_S = HWIDTH'(HSIZE);
  localparam logic [VWIDTH-1:0] VSIZE_S = VWIDTH'(VSIZE);
  localparam logic [HWIDTH:0]   HCLIP   = (HWIDTH+1)'(SCREEN_H);
  localparam logic [VWIDTH:0]   VCLIP   = (VWIDTH+1)'(SCREEN_V);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WAIT, S_WRITE, S_NEXT, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [HWIDTH-1:0]   hoffset_q, hoffset_d;
  logic [VWIDTH-1:0]   voffset_q, voffset_d;
  logic                hflip_q, hflip_d, vflip_q, vflip_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic [AWIDTH-1:0]   rom_addr_q, rom_addr_d;
  logic [HWIDTH-1:0]   fb_hdata_q, fb_hdata_d;
  logic [VWIDTH-1:0]   fb_vdata_q, fb_vdata_d;
  logic [DWIDTH-1:0]   fb_data_q, fb_data_d;
  logic                fb_valid_q, fb_valid_d;

  logic [HWIDTH-1:0]   h_sum, h_pix;
  logic [VWIDTH-1:0]   v_sum, v_pix;
  logic                skip, last_x;
  logic [XW-1:0]       nx;
  logic [YW-1:0]       ny;

  function automatic logic [AWIDTH-1:0] tex_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return AWIDTH'(y >> IWIDTH) * TEX_W + AWIDTH'(x >> IWIDTH);
  endfunction

  // Inverse of the scan-out transform, wrapping modulo the coordinate width.
  always_comb begin
    h_sum = HWIDTH'(x_q) + hoffset_q;
    v_sum = VWIDTH'(y_q) + voffset_q;
    h_pix = hflip_q ? HSIZE_S - h_sum : h_sum;
    v_pix = vflip_q ? VSIZE_S - v_sum : v_sum;
    skip  = ({1'b0, h_pix} >= HCLIP) || ({1'b0, v_pix} >= VCLIP) || (rom_data == TRANSP);
    last_x = (x_q == X_LAST);
    nx     = last_x ? '0 : x_q + 1'b1;
    ny     = last_x ? y_q + 1'b1 : y_q;
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    hoffset_d  = hoffset_q;
    voffset_d  = voffset_q;
    hflip_d    = hflip_q;
    vflip_d    = vflip_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rom_addr_d = rom_addr_q;
    fb_hdata_d = fb_hdata_q;
    fb_vdata_d = fb_vdata_q;
    fb_data_d  = fb_data_q;
    fb_valid_d = fb_valid_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          hoffset_d  = hoffset;
          voffset_d  = voffset;
          hflip_d    = hflip;
          vflip_d    = vflip;
          x_d        = '0;
          y_d        = '0;
          rom_addr_d = '0;
          busy_d     = 1'b1;
          state_d    = S_READ;
        end
      end
      S_READ: state_d = S_WAIT;
      S_WAIT: begin
        fb_data_d  = rom_data;
        fb_hdata_d = h_pix;
        fb_vdata_d = v_pix;
        if (skip) begin
          state_d = S_NEXT;
        end else begin
          fb_valid_d = 1'b1;
          state_d    = S_WRITE;
        end
      end
      S_WRITE: begin
        if (fb_ready) begin
          fb_valid_d = 1'b0;
          state_d    = S_NEXT;
        end
      end
      S_NEXT: begin
        x_d = nx;
        y_d = ny;
        if (last_x && (y_q == Y_LAST)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          // Address registered here so it is already stable during READ.
          rom_addr_d = tex_addr(nx, ny);
          state_d    = S_READ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      hoffset_q  <= '0;
      voffset_q  <= '0;
      hflip_q    <= 1'b0;
      vflip_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rom_addr_q <= '0;
      fb_hdata_q <= '0;
      fb_vdata_q <= '0;
      fb_data_q  <= '0;
      fb_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      hoffset_q  <= hoffset_d;
      voffset_q  <= voffset_d;
      hflip_q    <= hflip_d;
      vflip_q    <= vflip_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rom_addr_q <= rom_addr_d;
      fb_hdata_q <= fb_hdata_d;
      fb_vdata_q <= fb_vdata_d;
      fb_data_q  <= fb_data_d;
      fb_valid_q <= fb_valid_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rom_addr = rom_addr_q;
  assign fb_hdata = fb_hdata_q;
  assign fb_vdata = fb_vdata_q;
  assign fb_data  = fb_data_q;
  assign fb_valid = fb_valid_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: a 4x4 unscaled instance and a 4x4 instance with 2x scaling.
module tb_sprite_blitter;
  localparam int HW = 10;
  localparam int VW = 10;
  localparam int AW = 12;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, start2 = 1'b0;
  logic [HW-1:0] hoffset = '0;
  logic [VW-1:0] voffset = '0;
  logic          hflip = 1'b0, vflip = 1'b0;
  logic          fb_ready = 1'b1;
  logic          rom_transp = 1'b0;

  logic          busy, done, fb_valid, busy2, done2, fb_valid2;
  logic [AW-1:0] rom_addr, rom_addr2;
  logic [DW-1:0] rom_data, rom_data2, fb_data, fb_data2;
  logic [HW-1:0] fb_hdata, fb_hdata2;
  logic [VW-1:0] fb_vdata, fb_vdata2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sprite_blitter #(.HWIDTH(HW), .VWIDTH(VW), .AWIDTH(AW), .IWIDTH(0), .DWIDTH(DW),
                   .HSIZE(4), .VSIZE(4), .SCREEN_H(640), .SCREEN_V(480), .TRANSP(12'h000)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hoffset(hoffset), .voffset(voffset),
    .hflip(hflip), .vflip(vflip), .busy(busy), .done(done), .rom_addr(rom_addr),
    .rom_data(rom_data), .fb_hdata(fb_hdata), .fb_vdata(fb_vdata), .fb_data(fb_data),
    .fb_valid(fb_valid), .fb_ready(fb_ready)
  );

  sprite_blitter #(.HWIDTH(HW), .VWIDTH(VW), .AWIDTH(AW), .IWIDTH(1), .DWIDTH(DW),
                   .HSIZE(4), .VSIZE(4), .SCREEN_H(640), .SCREEN_V(480), .TRANSP(12'h000)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .hoffset(hoffset), .voffset(voffset),
    .hflip(hflip), .vflip(vflip), .busy(busy2), .done(done2), .rom_addr(rom_addr2),
    .rom_data(rom_data2), .fb_hdata(fb_hdata2), .fb_vdata(fb_vdata2), .fb_data(fb_data2),
    .fb_valid(fb_valid2), .fb_ready(fb_ready)
  );

  // Synchronous ROMs: texel = address + 1, optionally keying address 5 to transparent.
  always @(posedge clk) begin
    rom_data  <= (rom_transp && rom_addr == 12'd5) ? 12'd0 : rom_addr + 12'd1;
    rom_data2 <= rom_addr2 + 12'd1;
  end

  logic [HW-1:0] wr_x [0:511];
  logic [VW-1:0] wr_y [0:511];
  logic [DW-1:0] wr_d [0:511];
  int wr_n = 0, done_n = 0, done_cyc = 0;
  logic [HW-1:0] w2_x [0:63];
  logic [VW-1:0] w2_y [0:63];
  logic [DW-1:0] w2_d [0:63];
  int w2_n = 0, done2_n = 0;

  always @(negedge clk) begin
    if (fb_valid && fb_ready) begin
      wr_x[wr_n] <= fb_hdata;
      wr_y[wr_n] <= fb_vdata;
      wr_d[wr_n] <= fb_data;
      wr_n <= wr_n + 1;
      $display("write dut1 #%0d x=%0d y=%0d data=%0d", wr_n, fb_hdata, fb_vdata, fb_data);
    end
    if (done) begin
      done_n   <= done_n + 1;
      done_cyc <= cyc;
    end
    if (fb_valid2 && fb_ready && w2_n < 64) begin
      w2_x[w2_n] <= fb_hdata2;
      w2_y[w2_n] <= fb_vdata2;
      w2_d[w2_n] <= fb_data2;
      w2_n <= w2_n + 1;
      $display("write dut2 #%0d x=%0d y=%0d data=%0d", w2_n, fb_hdata2, fb_vdata2, fb_data2);
    end
    if (done2) done2_n <= done2_n + 1;
  end

  task automatic start_job(input logic which, input logic [HW-1:0] ho, input logic [VW-1:0] vo,
                           input logic hf, input logic vf, output int c0);
    @(posedge clk); #1;
    hoffset = ho; voffset = vo; hflip = hf; vflip = vf;
    if (which) start2 = 1'b1; else start = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    start = 1'b0; start2 = 1'b0;
  endtask

  task automatic wait_done(input int base, output logic timeout);
    timeout = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #2;
      if (done_n != base) begin timeout = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 7;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
    if (fb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", fb_valid); end
    if (rom_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0d want 0", rom_addr); end
    if (fb_hdata !== '0) begin errors++; $display("FAIL reset_hdata: got %0d want 0", fb_hdata); end
    if (fb_vdata !== '0) begin errors++; $display("FAIL reset_vdata: got %0d want 0", fb_vdata); end
    if (fb_data !== '0) begin errors++; $display("FAIL reset_data: got %0d want 0", fb_data); end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_basic();
    int c0, wb, db; logic to;
    wb = wr_n; db = done_n;
    start_job(1'b0, 10'd10, 10'd20, 1'b0, 1'b0, c0);
    @(negedge clk);
    checks += 2;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_c1: got %0b want 1", busy); end
    if (rom_addr !== 12'd0) begin errors++; $display("FAIL basic_addr_c1: got %0d want 0", rom_addr); end
    @(negedge clk);
    checks++;
    if (fb_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_c2: got %0b want 0", fb_valid); end
    @(negedge clk);
    checks++;
    if (fb_valid !== 1'b1 || fb_hdata !== 10'd10 || fb_vdata !== 10'd20 || fb_data !== 12'd1) begin
      errors++;
      $display("FAIL basic_first_c3: got v=%0b (%0d,%0d,%0d) want v=1 (10,20,1)", fb_valid, fb_hdata, fb_vdata, fb_data);
    end
    wait_done(db, to);
    checks += 3;
    if (to) begin errors++; $display("FAIL basic_timeout: got no done want done"); end
    if (done_cyc - c0 != 65) begin errors++; $display("FAIL basic_done_cycle: got %0d want 65", done_cyc - c0); end
    if (wr_n - wb != 16) begin errors++; $display("FAIL basic_count: got %0d want 16", wr_n - wb); end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (wr_x[wb+k] !== HW'(10 + k % 4) || wr_y[wb+k] !== VW'(20 + k / 4) || wr_d[wb+k] !== DW'(k + 1)) begin
        errors++;
        $display("FAIL basic_wr%0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", k, wr_x[wb+k], wr_y[wb+k], wr_d[wb+k], 10 + k % 4, 20 + k / 4, k + 1);
      end
    end
    repeat (3) @(posedge clk);
    checks++;
    if (done_n - db != 1) begin errors++; $display("FAIL basic_done_once: got %0d want 1", done_n - db); end
  endtask

  task automatic test_flip();
    int c0, wb, db; logic to;
    wb = wr_n; db = done_n;
    start_job(1'b0, 10'd0, 10'd0, 1'b1, 1'b1, c0);
    wait_done(db, to);
    checks += 2;
    if (to) begin errors++; $display("FAIL flip_timeout: got no done want done"); end
    if (wr_n - wb != 16) begin errors++; $display("FAIL flip_count: got %0d want 16", wr_n - wb); end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (wr_x[wb+k] !== HW'(4 - k % 4) || wr_y[wb+k] !== VW'(4 - k / 4) || wr_d[wb+k] !== DW'(k + 1)) begin
        errors++;
        $display("FAIL flip_wr%0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", k, wr_x[wb+k], wr_y[wb+k], wr_d[wb+k], 4 - k % 4, 4 - k / 4, k + 1);
      end
    end
  endtask

  task automatic test_clip();
    int c0, wb, db; logic to;
    wb = wr_n; db = done_n;
    start_job(1'b0, 10'd638, 10'd20, 1'b0, 1'b0, c0);
    wait_done(db, to);
    checks += 3;
    if (to) begin errors++; $display("FAIL clip_timeout: got no done want done"); end
    if (wr_n - wb != 8) begin errors++; $display("FAIL clip_count: got %0d want 8", wr_n - wb); end
    if (done_cyc - c0 != 57) begin errors++; $display("FAIL clip_done_cycle: got %0d want 57", done_cyc - c0); end
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (wr_x[wb+j] !== HW'(638 + j % 2) || wr_y[wb+j] !== VW'(20 + j / 2) || wr_d[wb+j] !== DW'((j / 2) * 4 + j % 2 + 1)) begin
        errors++;
        $display("FAIL clip_wr%0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", j, wr_x[wb+j], wr_y[wb+j], wr_d[wb+j], 638 + j % 2, 20 + j / 2, (j / 2) * 4 + j % 2 + 1);
      end
    end
  endtask

  task automatic test_transp();
    int c0, wb, db, k; logic to;
    wb = wr_n; db = done_n;
    rom_transp = 1'b1;
    start_job(1'b0, 10'd10, 10'd20, 1'b0, 1'b0, c0);
    wait_done(db, to);
    rom_transp = 1'b0;
    checks += 3;
    if (to) begin errors++; $display("FAIL transp_timeout: got no done want done"); end
    if (wr_n - wb != 15) begin errors++; $display("FAIL transp_count: got %0d want 15", wr_n - wb); end
    if (done_cyc - c0 != 64) begin errors++; $display("FAIL transp_done_cycle: got %0d want 64", done_cyc - c0); end
    for (int j = 0; j < 15; j++) begin
      k = (j < 5) ? j : j + 1;
      checks++;
      if (wr_x[wb+j] !== HW'(10 + k % 4) || wr_y[wb+j] !== VW'(20 + k / 4) || wr_d[wb+j] !== DW'(k + 1)) begin
        errors++;
        $display("FAIL transp_wr%0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", j, wr_x[wb+j], wr_y[wb+j], wr_d[wb+j], 10 + k % 4, 20 + k / 4, k + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    int c0, wb, db; logic to, found;
    wb = wr_n; db = done_n; found = 1'b0;
    start_job(1'b0, 10'd10, 10'd20, 1'b0, 1'b0, c0);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (fb_valid && wr_n == wb + 2) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL bp_third_write: got none want pending write"); end
    fb_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      checks++;
      if (fb_valid !== 1'b1 || fb_hdata !== 10'd12 || fb_vdata !== 10'd20 || fb_data !== 12'd3 || rom_addr !== 12'd2) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%0b (%0d,%0d,%0d) addr=%0d want v=1 (12,20,3) addr=2", s, fb_valid, fb_hdata, fb_vdata, fb_data, rom_addr);
      end
      @(posedge clk); #1;
    end
    fb_ready = 1'b1;
    wait_done(db, to);
    checks += 3;
    if (to) begin errors++; $display("FAIL bp_timeout: got no done want done"); end
    if (wr_n - wb != 16) begin errors++; $display("FAIL bp_count: got %0d want 16", wr_n - wb); end
    if (done_cyc - c0 != 70) begin errors++; $display("FAIL bp_done_cycle: got %0d want 70", done_cyc - c0); end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (wr_x[wb+k] !== HW'(10 + k % 4) || wr_y[wb+k] !== VW'(20 + k / 4) || wr_d[wb+k] !== DW'(k + 1)) begin
        errors++;
        $display("FAIL bp_wr%0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", k, wr_x[wb+k], wr_y[wb+k], wr_d[wb+k], 10 + k % 4, 20 + k / 4, k + 1);
      end
    end
  endtask

  task automatic test_scale();
    int c0, wb, db, a, got; int cnt [4]; logic to;
    wb = w2_n; db = done2_n; to = 1'b1;
    cnt = '{0, 0, 0, 0};
    start_job(1'b1, 10'd10, 10'd20, 1'b0, 1'b0, c0);
    checks++;
    if (busy2 !== 1'b1) begin errors++; $display("FAIL scale_busy: got %0b want 1", busy2); end
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #2;
      if (done2_n != db) begin to = 1'b0; break; end
    end
    checks += 2;
    if (to) begin errors++; $display("FAIL scale_timeout: got no done want done"); end
    if (w2_n - wb != 16) begin errors++; $display("FAIL scale_count: got %0d want 16", w2_n - wb); end
    for (int k = 0; k < 16; k++) begin
      a = ((k / 4) / 2) * 2 + (k % 4) / 2;
      checks++;
      if (w2_x[wb+k] !== HW'(10 + k % 4) || w2_y[wb+k] !== VW'(20 + k / 4) || w2_d[wb+k] !== DW'(a + 1)) begin
        errors++;
        $display("FAIL scale_wr%0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", k, w2_x[wb+k], w2_y[wb+k], w2_d[wb+k], 10 + k % 4, 20 + k / 4, a + 1);
      end
      got = int'(w2_d[wb+k]) - 1;
      if (got >= 0 && got < 4) cnt[got]++;
    end
    checks++;
    if (w2_d[wb+11] !== 12'd4) begin errors++; $display("FAIL scale_x3y2_addr: got %0d want 3", int'(w2_d[wb+11]) - 1); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cnt[i] != 4) begin errors++; $display("FAIL scale_addr%0d_uses: got %0d want 4", i, cnt[i]); end
    end
  endtask

  task automatic test_reset_midjob();
    int c0, wb, db, wr_at; logic to, found;
    found = 1'b0;
    start_job(1'b0, 10'd10, 10'd20, 1'b0, 1'b0, c0);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (fb_valid) begin found = 1'b1; break; end
    end
    db = done_n;
    rst_n = 1'b0;
    #1;
    checks += 8;
    if (!found) begin errors++; $display("FAIL rst_mid_valid_seen: got none want write pending"); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %0b want 0", busy); end
    if (fb_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %0b want 0", fb_valid); end
    if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got %0b want 0", done); end
    if (rom_addr !== '0) begin errors++; $display("FAIL rst_mid_addr: got %0d want 0", rom_addr); end
    if (fb_hdata !== '0) begin errors++; $display("FAIL rst_mid_hdata: got %0d want 0", fb_hdata); end
    if (fb_vdata !== '0) begin errors++; $display("FAIL rst_mid_vdata: got %0d want 0", fb_vdata); end
    if (fb_data !== '0) begin errors++; $display("FAIL rst_mid_data: got %0d want 0", fb_data); end
    @(posedge clk); #1 rst_n = 1'b1;
    wr_at = wr_n;
    repeat (100) @(posedge clk);
    #2;
    checks += 2;
    if (done_n != db) begin errors++; $display("FAIL rst_mid_no_done: got %0d pulses want 0", done_n - db); end
    if (wr_n != wr_at) begin errors++; $display("FAIL rst_mid_no_writes: got %0d writes want 0", wr_n - wr_at); end
    wb = wr_n; db = done_n;
    start_job(1'b0, 10'd10, 10'd20, 1'b0, 1'b0, c0);
    repeat (5) @(posedge clk);
    #1 hoffset = 10'd100; voffset = 10'd50; hflip = 1'b1; vflip = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(db, to);
    repeat (3) @(posedge clk);
    checks += 4;
    if (to) begin errors++; $display("FAIL rst_rerun_timeout: got no done want done"); end
    if (wr_n - wb != 16) begin errors++; $display("FAIL rst_rerun_count: got %0d want 16", wr_n - wb); end
    if (done_cyc - c0 != 65) begin errors++; $display("FAIL rst_rerun_done_cycle: got %0d want 65", done_cyc - c0); end
    if (done_n - db != 1) begin errors++; $display("FAIL rst_rerun_done_once: got %0d want 1", done_n - db); end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (wr_x[wb+k] !== HW'(10 + k % 4) || wr_y[wb+k] !== VW'(20 + k / 4) || wr_d[wb+k] !== DW'(k + 1)) begin
        errors++;
        $display("FAIL rst_rerun_wr%0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", k, wr_x[wb+k], wr_y[wb+k], wr_d[wb+k], 10 + k % 4, 20 + k / 4, k + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flip();
    test_clip();
    test_transp();
    test_backpressure();
    test_scale();
    test_reset_midjob();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
